pong_ball_engine: RTL and testbench

//   Parametrised ball/score engine for the pong game. Advances the ball once per video frame and bounces it off
//   the top/bottom walls and both paddles. Counts points, runs serve/game-over sequencing and exposes registered

---
 rtl/pong_ball_engine.sv | 212 +++++++++++++++++++++
 tb/tb_pong_ball_engine.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pong_ball_engine.sv
// Ball/score engine: steps the ball once per frame, bounces it off walls and paddles,
// counts points and sequences IDLE -> SERVE -> PLAY -> OVER. All outputs are registered.
module pong_ball_engine #(
   parameter int COORD_W      = 10,
   parameter int H_ACTIVE     = 640,
   parameter int V_ACTIVE     = 480,
   parameter int BALL_SIZE    = 8,
   parameter int PADDLE_H     = 64,
   parameter int PADDLE_W     = 8,
   parameter int PAD_L_X      = 16,
   parameter int PAD_R_X      = 616,
   parameter int VSTEP        = 2,
   parameter int MAX_SPEED    = 6,
   parameter int SCORE_W      = 4,
   parameter int WIN_SCORE    = 9,
   parameter int SERVE_FRAMES = 60
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic               frame_tick,
   input  logic               start,
   input  logic [COORD_W-1:0] pad_l_y,
   input  logic [COORD_W-1:0] pad_r_y,
   output logic [COORD_W-1:0] ball_x,
   output logic [COORD_W-1:0] ball_y,
   output logic [SCORE_W-1:0] score_l,
   output logic [SCORE_W-1:0] score_r,
   output logic               point_l,
   output logic               point_r,
   output logic               game_over,
   output logic               serving
);

   localparam int W1    = COORD_W + 1;
   localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

   localparam logic [COORD_W-1:0] CX        = COORD_W'((H_ACTIVE - BALL_SIZE) / 2);
   localparam logic [COORD_W-1:0] CY        = COORD_W'((V_ACTIVE - BALL_SIZE) / 2);
   localparam logic [COORD_W-1:0] Y_MAX     = COORD_W'(V_ACTIVE - BALL_SIZE);
   localparam logic [COORD_W-1:0] Y_STEP    = COORD_W'(VSTEP);
   localparam logic [COORD_W-1:0] X_BOUNCE_L = COORD_W'(PAD_L_X + PADDLE_W);
   localparam logic [COORD_W-1:0] X_BOUNCE_R = COORD_W'(PAD_R_X - BALL_SIZE);
   localparam logic [COORD_W-1:0] SPD_MAX   = COORD_W'(MAX_SPEED);
   localparam logic [COORD_W-1:0] SPD_ONE   = COORD_W'(1);
   localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SERVE_FRAMES - 1);
   localparam logic [SCORE_W-1:0] SCORE_WIN = SCORE_W'(WIN_SCORE);

   typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;

   state_t             state, state_nxt;
   logic [COORD_W-1:0] speed, x_n, y_n, spd_n, y_step;
   logic               dx, dy, dx_n, dy_n, dy_step;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [SCORE_W-1:0] sl_n, sr_n;
   logic               pl_n, pr_n;

   logic               tick, go;
   logic [W1-1:0]      bx, by, bs, pyl, pyr;
   logic               ov_l, ov_r, hit_l, hit_r, miss_l, miss_r, pt_l, pt_r, win;
   logic [COORD_W-1:0] spd_inc;

   assign tick = ena & frame_tick;
   assign go   = ena & start;

   // One extra bit on every intermediate so sums near the screen edge never wrap.
   assign bx  = {1'b0, ball_x};
   assign by  = {1'b0, ball_y};
   assign bs  = {1'b0, speed};
   assign pyl = {1'b0, pad_l_y};
   assign pyr = {1'b0, pad_r_y};

   assign ov_l   = (by + W1'(BALL_SIZE) > pyl) && (by < pyl + W1'(PADDLE_H));
   assign ov_r   = (by + W1'(BALL_SIZE) > pyr) && (by < pyr + W1'(PADDLE_H));
   assign hit_l  = (bx >= W1'(PAD_L_X)) && (bx <= W1'(PAD_L_X + PADDLE_W) + bs) && ov_l;
   assign miss_l = bx < bs;
   assign hit_r  = (bx + bs + W1'(BALL_SIZE) >= W1'(PAD_R_X)) &&
                   (bx + W1'(BALL_SIZE) <= W1'(PAD_R_X + PADDLE_W)) && ov_r;
   assign miss_r = bx + bs > W1'(H_ACTIVE - BALL_SIZE);
   assign pt_l   = dx && !hit_r && miss_r;
   assign pt_r   = !dx && !hit_l && miss_l;
   assign win    = pt_l ? (score_l + SCORE_W'(1) == SCORE_WIN) : (score_r + SCORE_W'(1) == SCORE_WIN);
   assign spd_inc = (speed >= SPD_MAX) ? SPD_MAX : speed + SPD_ONE;

   always_comb begin
      y_step  = ball_y;
      dy_step = dy;
      if (!dy) begin
         if (ball_y < Y_STEP) begin
            y_step  = '0;
            dy_step = 1'b1;
         end else begin
            y_step = ball_y - Y_STEP;
         end
      end else if (by + W1'(VSTEP) >= W1'(V_ACTIVE - BALL_SIZE)) begin
         y_step  = Y_MAX;
         dy_step = 1'b0;
      end else begin
         y_step = ball_y + Y_STEP;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else if (ena) state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, OVER: if (go) state_nxt = SERVE;
         SERVE:      if (tick && cnt == CNT_LAST) state_nxt = PLAY;
         PLAY:       if (tick && (pt_l || pt_r)) state_nxt = win ? OVER : SERVE;
         default:    state_nxt = IDLE;
      endcase
   end

   always_comb begin
      x_n   = ball_x;
      y_n   = ball_y;
      spd_n = speed;
      dx_n  = dx;
      dy_n  = dy;
      cnt_n = cnt;
      sl_n  = score_l;
      sr_n  = score_r;
      pl_n  = 1'b0;
      pr_n  = 1'b0;
      case (state)
         IDLE, OVER: begin
            x_n = CX;
            y_n = CY;
            if (go) begin
               sl_n  = '0;
               sr_n  = '0;
               dx_n  = 1'b1;
               spd_n = SPD_ONE;
               cnt_n = '0;
            end
         end
         SERVE: if (tick) cnt_n = cnt + CNT_W'(1);
         PLAY: if (tick) begin
            y_n  = y_step;
            dy_n = dy_step;
            if (dx) begin
               if (hit_r) begin
                  x_n   = X_BOUNCE_R;
                  dx_n  = 1'b0;
                  spd_n = spd_inc;
               end else if (miss_r) begin
                  sl_n = score_l + SCORE_W'(1);
                  pl_n = 1'b1;
                  dx_n = 1'b0;
               end else begin
                  x_n = ball_x + speed;
               end
            end else begin
               if (hit_l) begin
                  x_n   = X_BOUNCE_L;
                  dx_n  = 1'b1;
                  spd_n = spd_inc;
               end else if (miss_l) begin
                  sr_n = score_r + SCORE_W'(1);
                  pr_n = 1'b1;
                  dx_n = 1'b1;
               end else begin
                  x_n = ball_x - speed;
               end
            end
            // A point recentres the ball; the serve goes toward the scorer.
            if (pt_l || pt_r) begin
               x_n   = CX;
               y_n   = CY;
               spd_n = SPD_ONE;
               cnt_n = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ball_x    <= CX;
         ball_y    <= CY;
         speed     <= SPD_ONE;
         dx        <= 1'b1;
         dy        <= 1'b1;
         cnt       <= '0;
         score_l   <= '0;
         score_r   <= '0;
         point_l   <= 1'b0;
         point_r   <= 1'b0;
         serving   <= 1'b0;
         game_over <= 1'b0;
      end else if (ena) begin
         ball_x    <= x_n;
         ball_y    <= y_n;
         speed     <= spd_n;
         dx        <= dx_n;
         dy        <= dy_n;
         cnt       <= cnt_n;
         score_l   <= sl_n;
         score_r   <= sr_n;
         point_l   <= pl_n;
         point_r   <= pr_n;
         serving   <= (state_nxt == SERVE);
         game_over <= (state_nxt == OVER);
      end
   end

endmodule

// File: tb/tb_pong_ball_engine.sv
// Directed bench for pong_ball_engine: a table of frame-level phases with hand-computed
// ball positions, followed by paddle-speed, game-over, freeze and reset sequences.
module tb_pong_ball_engine;

   logic       clk = 1'b0;
   logic       rst_n, ena, frame_tick, start;
   logic [9:0] pad_l_y, pad_r_y;
   logic [9:0] ball_x, ball_y;
   logic [3:0] score_l, score_r;
   logic       point_l, point_r, game_over, serving;

   pong_ball_engine dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .frame_tick(frame_tick), .start(start),
      .pad_l_y(pad_l_y), .pad_r_y(pad_r_y), .ball_x(ball_x), .ball_y(ball_y),
      .score_l(score_l), .score_r(score_r), .point_l(point_l), .point_r(point_r),
      .game_over(game_over), .serving(serving)
   );

   always #5 clk = ~clk;

   int  passes = 0;
   int  total  = 0;
   int  pl_cnt = 0;
   int  pr_cnt = 0;
   bit  track_l = 1'b0;
   bit  track_r = 1'b0;

   // Count every cycle a point pulse is high, sampled mid-cycle.
   always @(posedge clk) begin
      #2;
      if (point_l) pl_cnt++;
      if (point_r) pr_cnt++;
   end

   localparam int K_IDLE   = 0;
   localparam int K_START  = 1;
   localparam int K_TICK   = 2;
   localparam int K_FROZEN = 3;

   typedef struct {
      int kind; int n; int pl; int pr;
      int x; int y; int sl; int sr; int serv; int over;
   } vec_t;

   vec_t vt[19];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task do_tick();
      @(negedge clk);
      if (track_l) pad_l_y = ball_y;
      if (track_r) pad_r_y = ball_y;
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
   endtask

   task pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   int exp_spd[5];
   int prev, delta, target;
   bit found;

   initial begin
      rst_n = 1'b0; ena = 1'b1; frame_tick = 1'b0; start = 1'b0;
      pad_l_y = '0; pad_r_y = '0;

      //           kind      n    pl   pr   x    y    sl sr sv ov
      vt[0]  = '{K_IDLE,    3,   0,   0, 316, 236, 0, 0, 0, 0};
      vt[1]  = '{K_START,   1,   0,   0, 316, 236, 0, 0, 1, 0};
      vt[2]  = '{K_TICK,   59,   0,   0, 316, 236, 0, 0, 1, 0};
      vt[3]  = '{K_TICK,    1,   0,   0, 316, 236, 0, 0, 0, 0};
      vt[4]  = '{K_TICK,    1,   0,   0, 317, 238, 0, 0, 0, 0};
      vt[5]  = '{K_FROZEN,  5,   0,   0, 317, 238, 0, 0, 0, 0};
      vt[6]  = '{K_TICK,  117,   0,   0, 434, 472, 0, 0, 0, 0};
      vt[7]  = '{K_TICK,    1,   0,   0, 435, 470, 0, 0, 0, 0};
      vt[8]  = '{K_TICK,  197,   0,   0, 632,  76, 0, 0, 0, 0};
      vt[9]  = '{K_TICK,    1,   0,   0, 316, 236, 1, 0, 1, 0};
      vt[10] = '{K_TICK,   59, 320,   0, 316, 236, 1, 0, 1, 0};
      vt[11] = '{K_TICK,    1, 320,   0, 316, 236, 1, 0, 0, 0};
      vt[12] = '{K_TICK,    1, 320,   0, 315, 234, 1, 0, 0, 0};
      vt[13] = '{K_TICK,  117, 320,   0, 198,   0, 1, 0, 0, 0};
      vt[14] = '{K_TICK,    1, 320,   0, 197,   0, 1, 0, 0, 0};
      vt[15] = '{K_TICK,    1, 320,   0, 196,   2, 1, 0, 0, 0};
      vt[16] = '{K_TICK,  171, 320,   0,  25, 344, 1, 0, 0, 0};
      vt[17] = '{K_TICK,    1, 320,   0,  24, 346, 1, 0, 0, 0};
      vt[18] = '{K_TICK,    1, 320,   0,  26, 348, 1, 0, 0, 0};

      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 19; i++) begin
         pad_l_y = 10'(vt[i].pl);
         pad_r_y = 10'(vt[i].pr);
         case (vt[i].kind)
            K_IDLE:  repeat (vt[i].n) @(negedge clk);
            K_START: pulse_start();
            K_TICK:  repeat (vt[i].n) do_tick();
            default: begin
               ena = 1'b0;
               repeat (vt[i].n) do_tick();
               pulse_start();
               ena = 1'b1;
            end
         endcase
         chk($sformatf("row%0d ball_x", i), ball_x, vt[i].x);
         chk($sformatf("row%0d ball_y", i), ball_y, vt[i].y);
         chk($sformatf("row%0d score_l", i), score_l, vt[i].sl);
         chk($sformatf("row%0d score_r", i), score_r, vt[i].sr);
         chk($sformatf("row%0d serving", i), serving, vt[i].serv);
         chk($sformatf("row%0d game_over", i), game_over, vt[i].over);
      end
      chk("point_l pulse cycles", pl_cnt, 1);
      chk("point_r pulse cycles", pr_cnt, 0);

      // Both paddles follow the ball: speed must climb by one per bounce and stop at 6.
      exp_spd = '{3, 4, 5, 6, 6};
      track_l = 1'b1;
      track_r = 1'b1;
      for (int b = 0; b < 5; b++) begin
         target = (b % 2 == 0) ? 608 : 24;
         found  = 1'b0;
         for (int t = 0; t < 400 && !found; t++) begin
            do_tick();
            if (ball_x == 10'(target)) found = 1'b1;
         end
         chk($sformatf("bounce%0d reached x=%0d", b, target), int'(found), 1);
         prev = ball_x;
         do_tick();
         delta = (target == 608) ? prev - int'(ball_x) : int'(ball_x) - prev;
         chk($sformatf("bounce%0d speed", b), delta, exp_spd[b]);
      end

      // Left paddle parked off-screen: right player wins 9 points.
      track_l = 1'b0;
      pad_l_y = 10'd1000;
      for (int t = 0; t < 20000 && !game_over; t++) do_tick();
      chk("over game_over", game_over, 1);
      chk("over score_r", score_r, 9);
      chk("over score_l", score_l, 1);
      chk("over ball_x", ball_x, 316);
      chk("over ball_y", ball_y, 236);
      chk("over serving", serving, 0);
      @(negedge clk);
      chk("point_r pulse cycles", pr_cnt, 9);
      chk("point_l pulse cycles final", pl_cnt, 1);

      repeat (5) do_tick();
      chk("over hold ball_x", ball_x, 316);
      chk("over hold score_r", score_r, 9);
      chk("over hold game_over", game_over, 1);

      // start and frame_tick together out of OVER: transition taken, tick not counted.
      @(negedge clk);
      start = 1'b1;
      frame_tick = 1'b1;
      @(negedge clk);
      start = 1'b0;
      frame_tick = 1'b0;
      chk("restart serving", serving, 1);
      chk("restart score_r", score_r, 0);
      chk("restart score_l", score_l, 0);
      chk("restart game_over", game_over, 0);
      repeat (30) do_tick();
      pulse_start();
      repeat (29) do_tick();
      chk("serve tick59 serving", serving, 1);
      do_tick();
      chk("serve tick60 serving", serving, 0);
      do_tick();
      chk("relaunch ball_x", ball_x, 317);

      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midplay reset ball_x", ball_x, 316);
      chk("midplay reset ball_y", ball_y, 236);
      chk("midplay reset serving", serving, 0);
      chk("midplay reset game_over", game_over, 0);
      chk("midplay reset score_l", score_l, 0);
      chk("midplay reset score_r", score_r, 0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
